// File: rtl/digit_serial_alu.sv
// Digit-serial ALU: processes WIDTH-bit operands DIGIT bits per clock,
// LSB digit first, with the carry held in a flop between digits.
// Supports AND, OR, ADD, SUB and SLT with zero/carry/overflow flags and a
// start/done handshake. Result and flags hold until the next operation ends.
module digit_serial_alu #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       ALUop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int REM_W = WIDTH - DIGIT;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Operand shift registers, latched opcode and inter-digit carry.
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [2:0]       op_q;
    logic             carry_q;
    // Holds the NDIG-1 digits already computed; the last digit is merged
    // combinationally, so the visible result only changes on completion.
    logic [REM_W-1:0] acc_sr;

    // Per-digit datapath signals.
    logic             invert_b;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   sum;
    logic [DIGIT-1:0] slice;
    logic             msb_cin;
    logic             dig_ovf;
    logic             slt_bit;
    logic             is_addsub;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] final_result;

    // Compute the current digit slice and the candidate final result/flags.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a value unassigned, which would infer a latch.
        slice        = '0;
        final_result = '0;

        invert_b  = (op_q == OP_SUB) || (op_q == OP_SLT);
        is_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);
        a_dig     = a_sr[DIGIT-1:0];
        b_dig     = invert_b ? ~b_sr[DIGIT-1:0] : b_sr[DIGIT-1:0];
        sum       = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};

        // Carry into the digit MSB recovered from the MSB sum bit.
        msb_cin = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ sum[DIGIT-1];
        dig_ovf = msb_cin ^ sum[DIGIT];
        slt_bit = sum[DIGIT-1] ^ dig_ovf;

        case (op_q)
            OP_AND:                 slice = a_dig & b_dig;
            OP_OR:                  slice = a_dig | b_dig;
            OP_ADD, OP_SUB, OP_SLT: slice = sum[DIGIT-1:0];
            default:                slice = '0;
        endcase

        acc_next = {slice, acc_sr};

        case (op_q)
            OP_AND, OP_OR, OP_ADD, OP_SUB: final_result = acc_next;
            OP_SLT:                        final_result = {{(WIDTH-1){1'b0}}, slt_bit};
            default:                       final_result = '0;
        endcase
    end

    // Datapath registers: load operands on accept, shift one digit per RUN cycle.
    // NOTE: these shift registers carry no reset; every bit is reloaded or shifted in before it is observed.
    always_ff @(posedge clk) begin
        if (state != RUN) begin
            if (start) begin
                a_sr    <= a;
                b_sr    <= b;
                op_q    <= ALUop;
                carry_q <= (ALUop == OP_SUB) || (ALUop == OP_SLT);
            end
        end else begin
            a_sr    <= a_sr >> DIGIT;
            b_sr    <= b_sr >> DIGIT;
            acc_sr  <= acc_next[WIDTH-1:DIGIT];
            carry_q <= sum[DIGIT];
        end
    end

    // Control FSM with registered handshake outputs, result and flags.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values, independent of statement order.
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        cnt   <= '0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(NDIG - 1)) begin
                        state     <= DONE;
                        ready     <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= final_result;
                        zero      <= (final_result == '0);
                        carry_out <= is_addsub & sum[DIGIT];
                        overflow  <= is_addsub & dig_ovf;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
